// File: rtl/nios_mult_pipe_cell_if.sv
// Operand/result handshake bundle for nios_mult_pipe_cell.
// in_acc exists only when MULT_CELL_ACCUM_EN is defined.
interface nios_mult_pipe_cell_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic              in_signed1;
  logic              in_signed2;
  logic [TAG_W-1:0]  in_tag;
`ifdef MULT_CELL_ACCUM_EN
  logic              in_acc;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_lo;
  logic [DATA_W-1:0] out_hi;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_src1, in_src2, in_signed1, in_signed2, in_tag,
`ifdef MULT_CELL_ACCUM_EN
    output in_acc,
`endif
    output out_ready,
    input  in_ready, out_valid, out_lo, out_hi, out_tag
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_signed1, in_signed2, in_tag,
`ifdef MULT_CELL_ACCUM_EN
    input  in_acc,
`endif
    input  out_ready,
    output in_ready, out_valid, out_lo, out_hi, out_tag
  );
endinterface

// File: rtl/nios_mult_pipe_cell.sv
// LATENCY-stage pipelined DATA_W x DATA_W multiplier built from SLICE_W slice products.
// Define MULT_CELL_ACCUM_EN to add the in_acc accumulate path in the output stage.
module nios_mult_pipe_cell #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input logic clk,
  input logic reset_n,
  nios_mult_pipe_cell_if.slave io_bus
);
  localparam int NS  = DATA_W / SLICE_W;
  localparam int NP  = NS * NS;
  localparam int PW  = 2 * DATA_W;
  localparam int PPW = 2 * (SLICE_W + 2);

  logic              w_adv;
  logic              w_accept;
  logic [DATA_W:0]   w_extA;
  logic [DATA_W:0]   w_extB;
  logic [PW-1:0]     w_pp      [NP];
  logic [PW-1:0]     w_next    [LATENCY][NP];
  logic              w_inValid [LATENCY];
  logic [TAG_W-1:0]  w_inTag   [LATENCY];
  logic              r_valid   [LATENCY];
  logic [TAG_W-1:0]  r_tag     [LATENCY];
  logic [PW-1:0]     r_terms   [LATENCY][NP];
`ifdef MULT_CELL_ACCUM_EN
  logic              w_inAcc   [LATENCY];
  logic              r_acc     [LATENCY];
`endif

  assign w_adv           = ~r_valid[LATENCY-1] | io_bus.out_ready;
  assign io_bus.in_ready = w_adv & reset_n;
  assign w_accept        = io_bus.in_valid & io_bus.in_ready;
  assign w_extA          = {io_bus.in_signed1 & io_bus.in_src1[DATA_W-1], io_bus.in_src1};
  assign w_extB          = {io_bus.in_signed2 & io_bus.in_src2[DATA_W-1], io_bus.in_src2};

  // Lower slices are unsigned; the top slice carries the extension bit and is signed.
  function automatic logic signed [PPW-1:0] sliceOf(input logic [DATA_W:0] x, input int idx);
    logic [DATA_W:0] t;
    t = x >> (idx * SLICE_W);
    if (idx == NS - 1) return {{(PPW-SLICE_W-1){t[SLICE_W]}}, t[SLICE_W:0]};
    else               return {{(PPW-SLICE_W){1'b0}}, t[SLICE_W-1:0]};
  endfunction

  function automatic logic [PW-1:0] partial(input logic [DATA_W:0] a, input logic [DATA_W:0] b,
                                            input int i, input int j);
    logic signed [PPW-1:0] p;
    logic [PW+PPW-1:0]     wide;
    p    = sliceOf(a, i) * sliceOf(b, j);
    wide = {{PW{p[PPW-1]}}, p};
    return wide[PW-1:0] << ((i + j) * SLICE_W);
  endfunction

  always_comb begin
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++)
        w_pp[i*NS+j] = partial(w_extA, w_extB, i, j);
  end

  // Stage 0 holds raw partials, middle stages halve the term count, the last stage sums everything.
  always_comb begin
    logic [PW-1:0] w_in [NP];
    logic [PW-1:0] w_sum;
    for (int s = 0; s < LATENCY; s++) begin
      w_inValid[s] = (s == 0) ? w_accept : r_valid[(s == 0) ? 0 : s - 1];
      w_inTag[s]   = (s == 0) ? io_bus.in_tag : r_tag[(s == 0) ? 0 : s - 1];
`ifdef MULT_CELL_ACCUM_EN
      w_inAcc[s]   = (s == 0) ? io_bus.in_acc : r_acc[(s == 0) ? 0 : s - 1];
`endif
      for (int k = 0; k < NP; k++) begin
        w_in[k]      = (s == 0) ? w_pp[k] : r_terms[(s == 0) ? 0 : s - 1][k];
        w_next[s][k] = '0;
      end
      w_sum = '0;
      if (s == LATENCY - 1) begin
        for (int k = 0; k < NP; k++) w_sum = w_sum + w_in[k];
`ifdef MULT_CELL_ACCUM_EN
        if (w_inAcc[s]) w_sum = w_sum + r_terms[LATENCY-1][0];
`endif
        w_next[s][0] = w_sum;
      end else if (s == 0) begin
        for (int k = 0; k < NP; k++) w_next[s][k] = w_in[k];
      end else begin
        for (int k = 0; k < (NP + 1) / 2; k++)
          w_next[s][k] = w_in[2*k] + ((2*k + 1 < NP) ? w_in[(2*k + 1 < NP) ? 2*k + 1 : 0] : '0);
      end
    end
  end

  // Data registers load only with a valid beat, so the output register doubles as acc_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_valid[s] <= 1'b0;
        r_tag[s]   <= '0;
`ifdef MULT_CELL_ACCUM_EN
        r_acc[s]   <= 1'b0;
`endif
        for (int k = 0; k < NP; k++) r_terms[s][k] <= '0;
      end
    end else if (w_adv) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_valid[s] <= w_inValid[s];
        if (w_inValid[s]) begin
          r_tag[s] <= w_inTag[s];
`ifdef MULT_CELL_ACCUM_EN
          r_acc[s] <= w_inAcc[s];
`endif
          for (int k = 0; k < NP; k++) r_terms[s][k] <= w_next[s][k];
        end
      end
    end
  end

  assign io_bus.out_valid = r_valid[LATENCY-1];
  assign io_bus.out_lo    = r_terms[LATENCY-1][0][DATA_W-1:0];
  assign io_bus.out_hi    = r_terms[LATENCY-1][0][PW-1:DATA_W];
  assign io_bus.out_tag   = r_tag[LATENCY-1];
endmodule

// File: tb/tb_nios_mult_pipe_cell.sv
// Directed bench for nios_mult_pipe_cell: vector table, streaming, stall, mid-op reset,
// and the accumulate chain when MULT_CELL_ACCUM_EN is defined.
module tb_nios_mult_pipe_cell;
  localparam int DATA_W  = 32;
  localparam int SLICE_W = 16;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 4;

  typedef struct {
    logic [31:0] src1;
    logic [31:0] src2;
    logic        s1;
    logic        s2;
    logic [3:0]  tag;
    logic [63:0] prod;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [63:0] modelLast;
  logic [31:0] beatA   [16];
  logic [31:0] beatB   [16];
  logic        beatAcc [16];
  logic [63:0] emitLog [16];
  logic [63:0] expQ [$];
  logic [3:0]  tagQ [$];
  int   sent, recv, firstEmit, lastEmit, stallAccepts, unstable;
  logic lastInReady;

  nios_mult_pipe_cell_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  nios_mult_pipe_cell #(
    .DATA_W(DATA_W), .SLICE_W(SLICE_W), .LATENCY(LATENCY), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_src1    = v.src1;
    bus.in_src2    = v.src2;
    bus.in_signed1 = v.s1;
    bus.in_signed2 = v.s2;
    bus.in_tag     = v.tag;
`ifdef MULT_CELL_ACCUM_EN
    bus.in_acc     = 1'b0;
`endif
    bus.out_ready  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 20);
  endtask

  // Drives beats from beatA/beatB and scores every emitted result against an in-order queue.
  task automatic runTraffic(input int nBeats, input int tagBase, input int stallStart, input int stallLen);
    logic [63:0] prevOut, e, got;
    logic        prevValid, prevStall, inStall, accNow, emitNow;
    sent = 0; recv = 0; firstEmit = -1; lastEmit = -1;
    stallAccepts = 0; unstable = 0; lastInReady = 1'b1;
    prevOut = '0; prevValid = 1'b0; prevStall = 1'b0;
    for (int c = 0; c < 200 && recv < nBeats; c++) begin
      @(negedge clk);
      inStall = (c >= stallStart) && (c < stallStart + stallLen);
      bus.out_ready = !inStall;
      if (sent < nBeats) begin
        bus.in_valid   = 1'b1;
        bus.in_src1    = beatA[sent];
        bus.in_src2    = beatB[sent];
        bus.in_signed1 = 1'b0;
        bus.in_signed2 = 1'b0;
        bus.in_tag     = TAG_W'(tagBase + sent);
`ifdef MULT_CELL_ACCUM_EN
        bus.in_acc     = beatAcc[sent];
`endif
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      accNow  = bus.in_valid && bus.in_ready;
      emitNow = bus.out_valid && bus.out_ready;
      got     = {bus.out_hi, bus.out_lo};
      if (inStall && prevStall && prevValid && bus.out_valid && got !== prevOut) unstable++;
      if (inStall) begin
        if (accNow) stallAccepts++;
        lastInReady = bus.in_ready;
      end
      if (emitNow) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedEmit", got, 64'hX);
        end else begin
          checkOutput($sformatf("stream%0d_prod", recv), got, expQ.pop_front());
          checkOutput($sformatf("stream%0d_tag", recv), 64'(bus.out_tag), 64'(tagQ.pop_front()));
        end
        if (recv < 16) emitLog[recv] = got;
        if (firstEmit < 0) firstEmit = c;
        lastEmit = c;
        recv++;
      end
      if (accNow) begin
        e = {32'b0, beatA[sent]} * {32'b0, beatB[sent]};
`ifdef MULT_CELL_ACCUM_EN
        if (beatAcc[sent]) e = e + modelLast;
`endif
        modelLast = e;
        expQ.push_back(e);
        tagQ.push_back(TAG_W'(tagBase + sent));
        sent++;
      end
      prevValid = bus.out_valid;
      prevOut   = got;
      prevStall = inStall;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("trafficCount", 64'(recv), 64'(nBeats));
  endtask

  task automatic checkDrained(input string name);
    int extra;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    checkOutput(name, 64'(extra), 64'd0);
  endtask

  initial begin
    vec_t vecs [13];
    int   lat;
    int   ghost;
    checks = 0; failures = 0; modelLast = '0;
    clk = 1'b0; reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_src1 = '0; bus.in_src2 = '0;
    bus.in_signed1 = 1'b0; bus.in_signed2 = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
`ifdef MULT_CELL_ACCUM_EN
    bus.in_acc = 1'b0;
`endif
    for (int k = 0; k < 16; k++) begin
      beatA[k] = '0; beatB[k] = '0; beatAcc[k] = 1'b0; emitLog[k] = '0;
    end

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd3,  64'hFFFFFFFE_00000001};
    vecs[1]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 4'd1,  64'h40000000_00000000};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd2,  64'hFFFFFFFF_00000001};
    vecs[3]  = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 4'd4,  64'h00000000_0000000C};
    vecs[4]  = '{32'h80000000, 32'h00000002, 1'b1, 1'b0, 4'd5,  64'hFFFFFFFF_00000000};
    vecs[5]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 4'd6,  64'h00000001_00000000};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd7,  64'hFFFFFFFF_80000000};
    vecs[7]  = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 4'd8,  64'hFFFFFFFF_FFFFFFEB};
    vecs[8]  = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 4'd9,  64'h00000000_FFFE0001};
    vecs[9]  = '{32'hFFFF0000, 32'h00010000, 1'b1, 1'b1, 4'd10, 64'hFFFFFFFF_00000000};
    vecs[10] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 4'd11, 64'h00000001_FFFFFFFE};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd12, 64'h00000000_00000001};
    vecs[12] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 4'd13, 64'hC0000000_80000000};

    repeat (3) @(negedge clk);
    checkOutput("resetValid",   64'(bus.out_valid), 64'd0);
    checkOutput("resetData",    {bus.out_hi, bus.out_lo}, 64'd0);
    checkOutput("resetTag",     64'(bus.out_tag), 64'd0);
    checkOutput("resetInReady", 64'(bus.in_ready), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idleInReady",  64'(bus.in_ready), 64'd1);

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v], lat);
      checkOutput($sformatf("vec%0d_prod", v), {bus.out_hi, bus.out_lo}, vecs[v].prod);
      checkOutput($sformatf("vec%0d_tag", v), 64'(bus.out_tag), 64'(vecs[v].tag));
      checkOutput($sformatf("vec%0d_latency", v), 64'(lat), 64'(LATENCY));
      modelLast = vecs[v].prod;
    end

    $display("[TB] streaming 8 back-to-back beats");
    for (int k = 0; k < 8; k++) begin
      beatA[k] = 32'hFFFFFFF0 + 32'(k);
      beatB[k] = 32'h00010003 * 32'(k + 1);
    end
    runTraffic(8, 0, 1000, 0);
    checkOutput("streamFirstEmit", 64'(firstEmit), 64'(LATENCY));
    checkOutput("streamContiguous", 64'(lastEmit - firstEmit), 64'd7);
    checkDrained("streamNoExtra");

    $display("[TB] stalling out_ready for 5 cycles");
    for (int k = 0; k < 6; k++) begin
      beatA[k] = 32'h12340000 + 32'(k * 7);
      beatB[k] = 32'h00000100 + 32'(k);
    end
    runTraffic(6, 8, 0, 5);
    checkOutput("stallAccepts",  64'(stallAccepts), 64'(LATENCY));
    checkOutput("stallInReady",  64'(lastInReady), 64'd0);
    checkOutput("stallUnstable", 64'(unstable), 64'd0);
    checkDrained("stallNoExtra");

    $display("[TB] reset with two ops in flight");
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_src1 = 32'd3; bus.in_src2 = 32'd5;
    bus.in_signed1 = 1'b0; bus.in_signed2 = 1'b0; bus.in_tag = 4'd5;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_src1 = 32'd9; bus.in_src2 = 32'd11; bus.in_tag = 4'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetValid",   64'(bus.out_valid), 64'd0);
    checkOutput("midResetData",    {bus.out_hi, bus.out_lo}, 64'd0);
    checkOutput("midResetTag",     64'(bus.out_tag), 64'd0);
    checkOutput("midResetInReady", 64'(bus.in_ready), 64'd0);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    modelLast = '0;
    ghost = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) ghost++;
    end
    checkOutput("midResetGhost", 64'(ghost), 64'd0);

`ifdef MULT_CELL_ACCUM_EN
    $display("[TB] accumulate chain");
    beatA[0] = 32'd3; beatB[0] = 32'd4; beatAcc[0] = 1'b0;
    beatA[1] = 32'd5; beatB[1] = 32'd6; beatAcc[1] = 1'b1;
    beatA[2] = 32'd2; beatB[2] = 32'd2; beatAcc[2] = 1'b1;
    beatA[3] = 32'd1; beatB[3] = 32'd7; beatAcc[3] = 1'b0;
    beatA[4] = 32'd1; beatB[4] = 32'd1; beatAcc[4] = 1'b1;
    runTraffic(5, 0, 1000, 0);
    checkOutput("acc0", emitLog[0], 64'd12);
    checkOutput("acc1", emitLog[1], 64'd42);
    checkOutput("acc2", emitLog[2], 64'd46);
    checkOutput("acc3", emitLog[3], 64'd7);
    checkOutput("acc4", emitLog[4], 64'd8);
    checkOutput("accContiguous", 64'(lastEmit - firstEmit), 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
